// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared widths, FSM encoding and bubble constant for hazard_ctrl
package hazard_ctrl_pkg;
  localparam int REG_BITS = 5;
  typedef enum logic {RUN = 1'b0, MULDIV = 1'b1} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/hazard_ctrl_muldiv_seq.sv
// muldiv_seq: mul/div latency FSM; busy on stall cycles, done on the final EX cycle
module muldiv_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_BITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);
  state_t state, state_n;
  logic [CNT_BITS-1:0] cnt, cnt_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    busy = !rst && (state == RUN ? start : (cnt > 1));
    done = !rst && state == MULDIV && cnt == 1;
    state_n = state == RUN ? (start ? MULDIV : RUN) : ((cnt > 1) ? MULDIV : RUN);
    cnt_n = state == RUN ? (start ? CNT_BITS'(MULDIV_LAT - 1) : '0) : cnt - CNT_BITS'(1);
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, branch-flush and mul/div stall control for the 5-stage pipeline
// Optional HAZARD_PERF_EN adds saturating stall_cycles/flush_cycles counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_BITS = hazard_ctrl_pkg::REG_BITS,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] IF_ID_RS,
  input  logic [REG_BITS-1:0] IF_ID_RT,
  input  logic                IF_ID_uses_rs,
  input  logic                IF_ID_uses_rt,
  input  logic                ID_EX_MemRead,
  input  logic [REG_BITS-1:0] ID_EX_RT,
  input  logic                EX_muldiv,
  input  logic                EX_branch_taken,
  output logic                PC_write,
  output logic                IF_ID_write,
  output logic                ID_EX_write,
  output logic                IF_ID_flush,
  output logic                ID_EX_flush,
  output logic                EX_MEM_flush,
  output logic                muldiv_busy,
  output logic                muldiv_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_cycles
`endif
);
  logic lu, br_flush, lu_stall;
  muldiv_seq #(.MULDIV_LAT(MULDIV_LAT), .CNT_BITS(CNT_BITS)) u_seq (
    .clk(clk), .rst(rst), .start(EX_muldiv), .busy(muldiv_busy), .done(muldiv_done)
  );
  assign lu = ID_EX_MemRead && ID_EX_RT != '0 &&
              ((IF_ID_uses_rs && IF_ID_RS == ID_EX_RT) || (IF_ID_uses_rt && IF_ID_RT == ID_EX_RT));
  assign br_flush = !rst && !muldiv_busy && EX_branch_taken;
  assign lu_stall = !rst && !muldiv_busy && !EX_branch_taken && lu;
  always_comb begin
    PC_write = !rst && !muldiv_busy && !lu_stall;
    IF_ID_write = !rst && !muldiv_busy && !lu_stall;
    ID_EX_write = !rst && !muldiv_busy;
    IF_ID_flush = rst || br_flush;
    ID_EX_flush = rst || br_flush || lu_stall;
    EX_MEM_flush = rst || muldiv_busy;
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if ((muldiv_busy || lu_stall) && ~&stall_cycles) stall_cycles <= stall_cycles + 32'd1;
      if (br_flush && ~&flush_cycles) flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif
`ifndef SYNTHESIS
  // mul/div and a taken branch cannot share EX; mul/div wins in the mux
  always_ff @(posedge clk)
    if (!rst) assert (!(EX_muldiv && EX_branch_taken))
      else $error("hazard_ctrl: EX_muldiv and EX_branch_taken asserted together");
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, directed sequences and random stimulus against a cycle-position model
module tb_hazard_ctrl;
  localparam int LAT = 4;
  localparam int RB = 5;
  logic clk = 1'b0;
  logic rst;
  logic [RB-1:0] rs, rt, ldrt;
  logic urs, urt, mr, md, br;
  logic PC_write, IF_ID_write, ID_EX_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush;
  logic muldiv_busy, muldiv_done;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif
  logic [5:0] act6;
  hazard_ctrl #(.REG_BITS(RB), .MULDIV_LAT(LAT), .CNT_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_RS(rs), .IF_ID_RT(rt), .IF_ID_uses_rs(urs), .IF_ID_uses_rt(urt),
    .ID_EX_MemRead(mr), .ID_EX_RT(ldrt), .EX_muldiv(md), .EX_branch_taken(br),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
  );
  assign act6 = {PC_write, IF_ID_write, ID_EX_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush};
  always #5 clk = ~clk;

  typedef struct {
    logic [RB-1:0] rs, rt, ldrt;
    logic urs, urt, mr, br;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[9];

  int errors = 0, checks = 0;
  int busy_cnt, done_cnt;
  bit m_active;
  int m_pos;
  longint m_stall, m_flush;
  bit vec_on;
  logic [5:0] vec_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    rs = 0; rt = 0; ldrt = 0; urs = 0; urt = 0; mr = 0; md = 0; br = 0;
  endtask

  // one clock: model predicts outputs from the mul/div cycle position, then advances
  task automatic tick();
    logic lu, e_stall, e_done;
    logic [5:0] e6;
    @(negedge clk);
    lu = mr && ldrt != 0 && ((urs && rs == ldrt) || (urt && rt == ldrt));
    e_stall = !rst && (m_active ? (m_pos < LAT - 1) : md);
    e_done = !rst && m_active && m_pos == LAT - 1;
    e6 = rst ? 6'b000_111 : e_stall ? 6'b000_001 : br ? 6'b111_110 : lu ? 6'b001_010 : 6'b111_000;
    chk("ctrl_outputs", {26'd0, act6}, {26'd0, e6});
    chk("muldiv_busy", {31'd0, muldiv_busy}, {31'd0, e_stall});
    chk("muldiv_done", {31'd0, muldiv_done}, {31'd0, e_done});
    if (vec_on) chk("vector", {26'd0, act6}, {26'd0, vec_exp});
`ifdef HAZARD_PERF_EN
    chk("stall_cycles", stall_cycles, 32'(m_stall));
    chk("flush_cycles", flush_cycles, 32'(m_flush));
`endif
    busy_cnt += int'(muldiv_busy);
    done_cnt += int'(muldiv_done);
    if (rst) begin
      m_active = 0; m_stall = 0; m_flush = 0;
    end else begin
      if ((e_stall || (!br && lu)) && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (!e_stall && br && m_flush < 64'hFFFF_FFFF) m_flush++;
      if (m_active) begin
        m_pos++;
        if (m_pos == LAT) m_active = 0;
      end else if (md) begin
        m_active = 1; m_pos = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{rs:5, rt:6, ldrt:5, urs:1, urt:1, mr:0, br:0, exp:6'b111_000};
    tbl[1] = '{rs:5, rt:6, ldrt:5, urs:1, urt:0, mr:1, br:0, exp:6'b001_010};
    tbl[2] = '{rs:0, rt:6, ldrt:0, urs:1, urt:1, mr:1, br:0, exp:6'b111_000};
    tbl[3] = '{rs:5, rt:6, ldrt:5, urs:0, urt:1, mr:1, br:0, exp:6'b111_000};
    tbl[4] = '{rs:1, rt:9, ldrt:9, urs:1, urt:1, mr:1, br:0, exp:6'b001_010};
    tbl[5] = '{rs:1, rt:9, ldrt:9, urs:1, urt:0, mr:1, br:0, exp:6'b111_000};
    tbl[6] = '{rs:5, rt:6, ldrt:5, urs:1, urt:0, mr:1, br:1, exp:6'b111_110};
    tbl[7] = '{rs:2, rt:3, ldrt:7, urs:1, urt:1, mr:1, br:1, exp:6'b111_110};
    tbl[8] = '{rs:31, rt:31, ldrt:31, urs:0, urt:1, mr:1, br:0, exp:6'b001_010};
    vec_on = 0; vec_exp = '0; busy_cnt = 0; done_cnt = 0; m_active = 0; m_pos = 0;
    m_stall = 0; m_flush = 0;
    set_idle();
    rst = 1;
    #1;
    tick(); tick();
    rst = 0;
    tick();
    foreach (tbl[i]) begin
      rs = tbl[i].rs; rt = tbl[i].rt; ldrt = tbl[i].ldrt; urs = tbl[i].urs;
      urt = tbl[i].urt; mr = tbl[i].mr; br = tbl[i].br;
      vec_exp = tbl[i].exp; vec_on = 1;
      tick();
      vec_on = 0;
    end
    set_idle();
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < LAT; k++) begin
      md = (k < 2);
      if (k == LAT - 1) begin mr = 1; ldrt = 5; rs = 5; urs = 1; end
      tick();
      if (k == LAT - 2) chk("no_early_done", done_cnt, 0);
    end
    chk("md_busy_cycles", busy_cnt, LAT - 1);
    chk("md_done_once", done_cnt, 1);
    set_idle();
    tick();
    md = 1;
    tick();
    md = 0; rst = 1;
    tick();
    rst = 0; done_cnt = 0;
    repeat (LAT + 1) tick();
    chk("abort_no_done", done_cnt, 0);
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      md = ($urandom_range(0, 9) == 0);
      br = !md && ($urandom_range(0, 6) == 0);
      rs = RB'($urandom_range(0, 3)); rt = RB'($urandom_range(0, 3));
      ldrt = RB'($urandom_range(0, 3));
      urs = 1'($urandom); urt = 1'($urandom); mr = 1'($urandom);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
